// File: rtl/spi_command_dispatcher_pkg.sv
// Shared command codes, payload lengths, dispatcher state encoding and the draw request record.
package spi_command_dispatcher_pkg;

  localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'h01;
  localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h02;

  localparam int SAVE_PAYLOAD_LEN = 513;
  localparam int DRAW_PAYLOAD_LEN = 6;

  typedef logic [1:0] dispatch_state_t;
  localparam dispatch_state_t ST_IDLE = 2'd0;
  localparam dispatch_state_t ST_SAVE = 2'd1;
  localparam dispatch_state_t ST_DRAW = 2'd2;
  localparam dispatch_state_t ST_SKIP = 2'd3;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  layer;
  } draw_req_t;

endpackage

// File: rtl/spi_command_dispatcher_if.sv
// Byte stream in, sprite RAM writes and draw requests out. SPI_DISPATCH_STATS_EN adds the stat counters.
interface spi_command_dispatcher_if #(
  parameter int ADDR_W = 15
);
  logic              rx_valid;
  logic [7:0]        rx_cmd;
  logic [7:0]        rx_data;
  logic [15:0]       rx_index;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              sprite_done;
  logic              draw_valid;
  logic              draw_ready;
  logic [7:0]        draw_id;
  logic [15:0]       draw_x;
  logic [15:0]       draw_y;
  logic [7:0]        draw_layer;
  logic              draw_overflow;
`ifdef SPI_DISPATCH_STATS_EN
  logic [15:0]       stat_sprites;
  logic [15:0]       stat_draws;

  modport master (
    output rx_valid, rx_cmd, rx_data, rx_index, draw_ready,
    input  mem_we, mem_addr, mem_wdata, sprite_done, draw_valid, draw_id, draw_x, draw_y,
           draw_layer, draw_overflow, stat_sprites, stat_draws
  );
  modport slave (
    input  rx_valid, rx_cmd, rx_data, rx_index, draw_ready,
    output mem_we, mem_addr, mem_wdata, sprite_done, draw_valid, draw_id, draw_x, draw_y,
           draw_layer, draw_overflow, stat_sprites, stat_draws
  );
`else
  modport master (
    output rx_valid, rx_cmd, rx_data, rx_index, draw_ready,
    input  mem_we, mem_addr, mem_wdata, sprite_done, draw_valid, draw_id, draw_x, draw_y,
           draw_layer, draw_overflow
  );
  modport slave (
    input  rx_valid, rx_cmd, rx_data, rx_index, draw_ready,
    output mem_we, mem_addr, mem_wdata, sprite_done, draw_valid, draw_id, draw_x, draw_y,
           draw_layer, draw_overflow
  );
`endif
endinterface

// File: rtl/spi_command_dispatcher_fifo.sv
// First-word-fall-through draw request queue; a push into a full queue is accepted only alongside a pop.
module spi_command_dispatcher_fifo
  import spi_command_dispatcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  draw_req_t push_data,
  input  logic      pop,
  output logic      push_ok,
  output logic      head_valid,
  output draw_req_t head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  draw_req_t        mem_q [DEPTH];
  draw_req_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_ok;

  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign pop_ok     = pop && head_valid;
  assign push_ok    = push && ((count_q != FULL_CNT) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_command_dispatcher.sv
// Turns decoded SPI bytes into sprite RAM writes (SAVE) and queued draw requests (DRAW).
// Optional SPI_DISPATCH_STATS_EN adds saturating sprite/draw counters.
module spi_command_dispatcher
  import spi_command_dispatcher_pkg::*;
#(
  parameter int SPRITE_ID_W     = 6,
  parameter int PIX_BYTES       = 512,
  parameter int DRAW_FIFO_DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  spi_command_dispatcher_if.slave bus
);
  localparam int PIX_W  = $clog2(PIX_BYTES);
  localparam int ADDR_W = SPRITE_ID_W + PIX_W;
  localparam logic [15:0] LAST_SAVE_IDX = 16'(PIX_BYTES + 1);
  localparam logic [15:0] LAST_DRAW_IDX = 16'(DRAW_PAYLOAD_LEN);
  localparam logic [31:0] ID_LIMIT      = 32'(1) << SPRITE_ID_W;

  dispatch_state_t        state_q, state_d;
  logic [SPRITE_ID_W-1:0] id_q, id_d;
  draw_req_t              req_q, req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   sprite_done_q, sprite_done_d;
  logic                   push_q, push_d;
  logic                   overflow_q, overflow_d;
  logic                   push_ok;
  logic                   head_valid;
  draw_req_t              head;
  logic [PIX_W-1:0]       pix_off;

  // payload byte n-1 arrives with index n, and pixel bytes start after the id byte
  assign pix_off = PIX_W'(bus.rx_index - 16'd2);

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    req_d         = req_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    sprite_done_d = 1'b0;
    push_d        = 1'b0;
    overflow_d    = overflow_q | (push_q & ~push_ok);
    if (bus.rx_valid) begin
      if (bus.rx_index == 16'd0) begin
        case (bus.rx_cmd)
          COMMAND_SAVE_SPRITE: state_d = ST_SAVE;
          COMMAND_DRAW_SPRITE: state_d = ST_DRAW;
          default:             state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_SAVE: begin
            if (bus.rx_index == 16'd1) begin
              if ({24'd0, bus.rx_data} >= ID_LIMIT) begin
                state_d = ST_SKIP;
              end else begin
                id_d = bus.rx_data[SPRITE_ID_W-1:0];
              end
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {id_q, pix_off};
              mem_wdata_d = bus.rx_data;
              if (bus.rx_index == LAST_SAVE_IDX) begin
                sprite_done_d = 1'b1;
                state_d       = ST_IDLE;
              end
            end
          end
          ST_DRAW: begin
            case (bus.rx_index)
              16'd1: req_d.id       = bus.rx_data;
              16'd2: req_d.x[15:8]  = bus.rx_data;
              16'd3: req_d.x[7:0]   = bus.rx_data;
              16'd4: req_d.y[15:8]  = bus.rx_data;
              16'd5: req_d.y[7:0]   = bus.rx_data;
              LAST_DRAW_IDX: begin
                req_d.layer = bus.rx_data;
                push_d      = 1'b1;
                state_d     = ST_IDLE;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      req_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      sprite_done_q <= 1'b0;
      push_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      req_q         <= req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      sprite_done_q <= sprite_done_d;
      push_q        <= push_d;
      overflow_q    <= overflow_d;
    end
  end

  spi_command_dispatcher_fifo #(
    .DEPTH(DRAW_FIFO_DEPTH)
  ) u_draw_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_q),
    .push_data  (req_q),
    .pop        (bus.draw_ready),
    .push_ok    (push_ok),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.sprite_done   = sprite_done_q;
  assign bus.draw_valid    = head_valid;
  assign bus.draw_id       = head.id;
  assign bus.draw_x        = head.x;
  assign bus.draw_y        = head.y;
  assign bus.draw_layer    = head.layer;
  assign bus.draw_overflow = overflow_q;

`ifdef SPI_DISPATCH_STATS_EN
  logic [15:0] stat_sprites_q, stat_sprites_d;
  logic [15:0] stat_draws_q, stat_draws_d;

  always_comb begin
    stat_sprites_d = stat_sprites_q;
    stat_draws_d   = stat_draws_q;
    if (sprite_done_q && (stat_sprites_q != 16'hFFFF)) begin
      stat_sprites_d = stat_sprites_q + 16'd1;
    end
    if (push_ok && (stat_draws_q != 16'hFFFF)) begin
      stat_draws_d = stat_draws_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_sprites_q <= '0;
      stat_draws_q   <= '0;
    end else begin
      stat_sprites_q <= stat_sprites_d;
      stat_draws_q   <= stat_draws_d;
    end
  end

  assign bus.stat_sprites = stat_sprites_q;
  assign bus.stat_draws   = stat_draws_q;
`endif

endmodule
